// File: rtl/fma_dot_seq_if.sv
// Job, operand-stream, FMA-wiring and result signals of the dot-product sequencer.
// master = job/stream producer, result consumer and external FMA; slave = the sequencer.
interface fma_dot_seq_if #(
  parameter int LEN_W = 8
);
  logic             start;
  logic [31:0]      bias;
  logic [LEN_W-1:0] len;
  logic             busy;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;

  logic [31:0]      fma_a;
  logic [31:0]      fma_b;
  logic [31:0]      fma_c;
  logic [31:0]      fma_d;

  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             res_nan;

  modport master (
    output start, bias, len, in_valid, in_a, in_b, fma_d, res_ready,
    input  busy, in_ready, fma_a, fma_b, fma_c, res_valid, res_data, res_nan
  );

  modport slave (
    input  start, bias, len, in_valid, in_a, in_b, fma_d, res_ready,
    output busy, in_ready, fma_a, fma_b, fma_c, res_valid, res_data, res_nan
  );
endinterface

// File: rtl/fma_dot_seq.sv
// Dot-product-plus-bias sequencer: feeds one operand pair per cycle to an external
// combinational FMA and chains the accumulator through its c input.
module fma_dot_seq #(
  parameter int LEN_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fma_dot_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] NAN_PATTERN = 32'hFFFF_FFFF;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic             op_vld_q, op_vld_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             nan_flag_q, nan_flag_d;

  logic in_ready;
  logic handshake;
  logic res_valid;

  // Guarding in_ready on remaining is what keeps the counter from wrapping.
  assign in_ready  = (state_q == ST_RUN) && (remaining_q != '0);
  assign handshake = bus.in_valid && in_ready;
  assign res_valid = (state_q == ST_DONE);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_vld_d    = 1'b0;
    remaining_d = remaining_q;
    nan_flag_d  = nan_flag_q;

    // The FMA result is only meaningful when the operand registers hold a live pair.
    if (op_vld_q) begin
      acc_d = bus.fma_d;
      if (bus.fma_d == NAN_PATTERN) begin
        nan_flag_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d       = bus.bias;
          remaining_d = bus.len;
          nan_flag_d  = 1'b0;
          state_d     = (bus.len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (handshake) begin
          op_a_d      = bus.in_a;
          op_b_d      = bus.in_b;
          op_vld_d    = 1'b1;
          remaining_d = remaining_q - LEN_W'(1);
        end
        // Final pair is in the FMA: its result lands in acc on this same edge.
        if (op_vld_q && (remaining_q == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_vld_q    <= 1'b0;
      remaining_q <= '0;
      nan_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_vld_q    <= op_vld_d;
      remaining_q <= remaining_d;
      nan_flag_q  <= nan_flag_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.fma_a     = op_a_q;
  assign bus.fma_b     = op_b_q;
  assign bus.fma_c     = acc_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_valid ? acc_q : '0;
  assign bus.res_nan   = res_valid ? nan_flag_q : 1'b0;

endmodule
